// File: rtl/axi_pkg.sv
// AXI4 burst/response encodings and engine state types for the memory responder.
// Constants only: no latency, no flow control.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP plus burst legality; purely combinational.
// Latency 0; no flow control. Illegal bursts (reserved type, bad WRAP length) advance as INCR.
module axi_burst_addr
   import axi_pkg::*;
(
   input  logic [63:0] addr,
   input  logic [7:0]  len,
   input  logic [1:0]  burst,
   output logic [63:0] next_addr,
   output logic        bad_burst
);

   logic        wrap_len_ok;
   logic [63:0] incr;
   logic [63:0] mask;

   always_comb begin
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      bad_burst   = (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
      incr        = addr + 64'd8;
      // (len+1)*8-1 is just len with three low ones appended
      mask        = {53'd0, len, 3'b111};
      next_addr   = incr;
      if (burst == BURST_FIXED)
         next_addr = addr;
      else if ((burst == BURST_WRAP) && wrap_len_ok)
         next_addr = (addr & ~mask) | (incr & mask);
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder terminating the L3 64-bit memory port on an on-chip word array.
// Latency: B 1 cycle after last W, first R 2 cycles after AR then 1 beat/2 cycles; B/R held stable until BREADY/RREADY.
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int          DEPTH_LOG2 = 14,
   parameter string       INIT_FILE  = ""
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        MEM_AWID,
   input  logic [63:0] MEM_AWADDR,
   input  logic [7:0]  MEM_AWLEN,
   input  logic [1:0]  MEM_AWBURST,
   input  logic        MEM_AWVALID,
   output logic        MEM_AWREADY,
   input  logic [63:0] MEM_WDATA,
   input  logic [7:0]  MEM_WSTRB,
   input  logic        MEM_WLAST,
   input  logic        MEM_WVALID,
   output logic        MEM_WREADY,
   output logic        MEM_BID,
   output logic [1:0]  MEM_BRESP,
   output logic        MEM_BVALID,
   input  logic        MEM_BREADY,
   input  logic        MEM_ARID,
   input  logic [63:0] MEM_ARADDR,
   input  logic [7:0]  MEM_ARLEN,
   input  logic [1:0]  MEM_ARBURST,
   input  logic        MEM_ARVALID,
   output logic        MEM_ARREADY,
   output logic        MEM_RID,
   output logic [63:0] MEM_RDATA,
   output logic [1:0]  MEM_RRESP,
   output logic        MEM_RLAST,
   output logic        MEM_RVALID,
   input  logic        MEM_RREADY
);

   localparam logic [63:0] SPAN = 64'd8 << DEPTH_LOG2;

   logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

   // ---------------- write engine ----------------
   w_state_e               w_state, w_state_nxt;
   logic                   w_id;
   logic [63:0]            w_addr, w_next, w_off;
   logic [7:0]             w_len, w_cnt;
   logic [1:0]             w_burst;
   logic                   w_slverr, w_decerr, w_bad, w_in, w_final, w_lerr;
   logic                   aw_fire, w_fire;
   logic [DEPTH_LOG2-1:0]  w_idx;
   logic                   awready_nxt, wready_nxt, bvalid_nxt, bid_nxt;
   logic [1:0]             bresp_nxt;

   axi_burst_addr u_waddr (
      .addr      (w_addr),
      .len       (w_len),
      .burst     (w_burst),
      .next_addr (w_next),
      .bad_burst (w_bad)
   );

   assign w_off   = w_addr - BASE_ADDR;
   assign w_in    = w_off < SPAN;
   assign w_idx   = w_off[DEPTH_LOG2+2:3];
   assign w_final = (w_cnt == w_len);
   assign w_lerr  = MEM_WLAST != w_final;
   assign aw_fire = (w_state == W_IDLE) && MEM_AWREADY && MEM_AWVALID;
   assign w_fire  = RSTn && (w_state == W_DATA) && MEM_WREADY && MEM_WVALID;

   always_comb begin
      w_state_nxt = w_state;
      awready_nxt = MEM_AWREADY;
      wready_nxt  = MEM_WREADY;
      bvalid_nxt  = MEM_BVALID;
      bid_nxt     = MEM_BID;
      bresp_nxt   = MEM_BRESP;
      case (w_state)
         W_IDLE: begin
            awready_nxt = 1'b1;
            if (aw_fire) begin
               w_state_nxt = W_DATA;
               awready_nxt = 1'b0;
               wready_nxt  = 1'b1;
            end
         end
         W_DATA: begin
            if (w_fire && w_final) begin
               w_state_nxt = W_RESP;
               wready_nxt  = 1'b0;
               bvalid_nxt  = 1'b1;
               bid_nxt     = w_id;
               if (w_decerr || !w_in)
                  bresp_nxt = RESP_DECERR;
               else if (w_slverr || w_lerr || w_bad)
                  bresp_nxt = RESP_SLVERR;
               else
                  bresp_nxt = RESP_OKAY;
            end
         end
         W_RESP: begin
            if (MEM_BREADY) begin
               w_state_nxt = W_IDLE;
               bvalid_nxt  = 1'b0;
               awready_nxt = 1'b1;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         w_state     <= W_IDLE;
         MEM_AWREADY <= 1'b0;
         MEM_WREADY  <= 1'b0;
         MEM_BVALID  <= 1'b0;
         MEM_BID     <= 1'b0;
         MEM_BRESP   <= RESP_OKAY;
      end else begin
         w_state     <= w_state_nxt;
         MEM_AWREADY <= awready_nxt;
         MEM_WREADY  <= wready_nxt;
         MEM_BVALID  <= bvalid_nxt;
         MEM_BID     <= bid_nxt;
         MEM_BRESP   <= bresp_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         w_id     <= 1'b0;
         w_addr   <= '0;
         w_len    <= '0;
         w_burst  <= BURST_FIXED;
         w_cnt    <= '0;
         w_slverr <= 1'b0;
         w_decerr <= 1'b0;
      end else if (aw_fire) begin
         w_id     <= MEM_AWID;
         w_addr   <= MEM_AWADDR;
         w_len    <= MEM_AWLEN;
         w_burst  <= MEM_AWBURST;
         w_cnt    <= '0;
         w_slverr <= 1'b0;
         w_decerr <= 1'b0;
      end else if (w_fire) begin
         w_addr   <= w_next;
         w_cnt    <= w_cnt + 8'd1;
         w_slverr <= w_slverr | w_lerr;
         w_decerr <= w_decerr | ~w_in;
      end
   end

   // Array contents survive reset; only strobed in-range bytes are written
   always_ff @(posedge CLK) begin
      if (w_fire && w_in) begin
         for (int b = 0; b < 8; b++)
            if (MEM_WSTRB[b])
               mem[w_idx][8*b +: 8] <= MEM_WDATA[8*b +: 8];
      end
   end

   // ---------------- read engine ----------------
   r_state_e               r_state, r_state_nxt;
   logic                   r_id;
   logic [63:0]            r_addr, r_next, r_off;
   logic [7:0]             r_len, r_cnt;
   logic [1:0]             r_burst;
   logic                   r_bad, r_in, ar_fire, r_adv;
   logic [DEPTH_LOG2-1:0]  r_idx;
   logic                   arready_nxt, rvalid_nxt;

   axi_burst_addr u_raddr (
      .addr      (r_addr),
      .len       (r_len),
      .burst     (r_burst),
      .next_addr (r_next),
      .bad_burst (r_bad)
   );

   assign r_off   = r_addr - BASE_ADDR;
   assign r_in    = r_off < SPAN;
   assign r_idx   = r_off[DEPTH_LOG2+2:3];
   assign ar_fire = (r_state == R_IDLE) && MEM_ARREADY && MEM_ARVALID;
   assign r_adv   = (r_state == R_DATA) && MEM_RREADY && !MEM_RLAST;

   always_comb begin
      r_state_nxt = r_state;
      arready_nxt = MEM_ARREADY;
      rvalid_nxt  = MEM_RVALID;
      case (r_state)
         R_IDLE: begin
            arready_nxt = 1'b1;
            if (ar_fire) begin
               r_state_nxt = R_FETCH;
               arready_nxt = 1'b0;
            end
         end
         R_FETCH: begin
            r_state_nxt = R_DATA;
            rvalid_nxt  = 1'b1;
         end
         R_DATA: begin
            if (MEM_RREADY) begin
               rvalid_nxt = 1'b0;
               if (MEM_RLAST) begin
                  r_state_nxt = R_IDLE;
                  arready_nxt = 1'b1;
               end else begin
                  r_state_nxt = R_FETCH;
               end
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state     <= R_IDLE;
         MEM_ARREADY <= 1'b0;
         MEM_RVALID  <= 1'b0;
      end else begin
         r_state     <= r_state_nxt;
         MEM_ARREADY <= arready_nxt;
         MEM_RVALID  <= rvalid_nxt;
      end
   end

   // Registered array read during FETCH; a same-cycle write to the word is seen next beat
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         MEM_RDATA <= '0;
         MEM_RRESP <= RESP_OKAY;
         MEM_RLAST <= 1'b0;
         MEM_RID   <= 1'b0;
         r_id      <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_burst   <= BURST_FIXED;
         r_cnt     <= '0;
      end else begin
         if (ar_fire) begin
            r_id    <= MEM_ARID;
            r_addr  <= MEM_ARADDR;
            r_len   <= MEM_ARLEN;
            r_burst <= MEM_ARBURST;
            r_cnt   <= '0;
         end
         if (r_state == R_FETCH) begin
            MEM_RDATA <= r_in ? mem[r_idx] : 64'd0;
            MEM_RRESP <= !r_in ? RESP_DECERR : (r_bad ? RESP_SLVERR : RESP_OKAY);
            MEM_RLAST <= (r_cnt == r_len);
            MEM_RID   <= r_id;
         end
         if (r_adv) begin
            r_addr <= r_next;
            r_cnt  <= r_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized AXI4 traffic against an address/strobe-level memory model of axi_mem_slave.
// Directed cases cover wrap order, strobes, DECERR/SLVERR, RREADY stalls, concurrency and reset.
module tb_axi_mem_slave;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SPAN = 64'd8 << 14;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        MEM_AWID = 1'b0;
   logic [63:0] MEM_AWADDR = '0;
   logic [7:0]  MEM_AWLEN = '0;
   logic [1:0]  MEM_AWBURST = '0;
   logic        MEM_AWVALID = 1'b0;
   logic        MEM_AWREADY;
   logic [63:0] MEM_WDATA = '0;
   logic [7:0]  MEM_WSTRB = '0;
   logic        MEM_WLAST = 1'b0;
   logic        MEM_WVALID = 1'b0;
   logic        MEM_WREADY;
   logic        MEM_BID;
   logic [1:0]  MEM_BRESP;
   logic        MEM_BVALID;
   logic        MEM_BREADY = 1'b0;
   logic        MEM_ARID = 1'b0;
   logic [63:0] MEM_ARADDR = '0;
   logic [7:0]  MEM_ARLEN = '0;
   logic [1:0]  MEM_ARBURST = '0;
   logic        MEM_ARVALID = 1'b0;
   logic        MEM_ARREADY;
   logic        MEM_RID;
   logic [63:0] MEM_RDATA;
   logic [1:0]  MEM_RRESP;
   logic        MEM_RLAST;
   logic        MEM_RVALID;
   logic        MEM_RREADY = 1'b0;

   axi_mem_slave dut (
      .CLK(CLK), .RSTn(RSTn),
      .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
      .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
      .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
      .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
      .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
      .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
      .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
      .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
      .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] ref_mem [logic [63:0]];
   logic [63:0] wd [256];
   logic [7:0]  ws [256];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit burst_bad(input logic [7:0] len, input logic [1:0] burst);
      return (burst == 2'b11) ||
             (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   function automatic bit in_range(input logic [63:0] a);
      return (a - BASE) < SPAN;
   endfunction

   // Address of beat i, from the burst definitions (wrap = modulo within the aligned block)
   function automatic logic [63:0] beat_addr(input logic [63:0] a0, input logic [7:0] len,
                                             input logic [1:0] burst, input int i);
      logic [63:0] size, blk, step;
      step = 64'(i) * 64'd8;
      if (burst == 2'b00) return a0;
      if (burst == 2'b10 && !burst_bad(len, burst)) begin
         size = (64'(len) + 64'd1) * 64'd8;
         blk  = a0 - (a0 % size);
         return blk + ((a0 - blk + step) % size);
      end
      return a0 + step;
   endfunction

   task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input int last_at, input int bhold);
      int t;
      logic [63:0] a, idx, cur;
      bit dec, slv;
      logic [1:0] exp_resp;
      @(negedge CLK);
      MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = len; MEM_AWBURST = burst; MEM_AWVALID = 1'b1;
      t = 0;
      while (!MEM_AWREADY && t < 200) begin @(negedge CLK); t++; end
      check_val("awready", 64'(MEM_AWREADY), 64'd1);
      @(negedge CLK);
      MEM_AWVALID = 1'b0;
      dec = 1'b0;
      slv = burst_bad(len, burst);
      for (int i = 0; i <= int'(len); i++) begin
         if ($urandom_range(0, 3) == 0) begin MEM_WVALID = 1'b0; @(negedge CLK); end
         MEM_WDATA = wd[i];
         MEM_WSTRB = ws[i];
         MEM_WLAST = (last_at < 0) ? (i == int'(len)) : (i == last_at);
         if (MEM_WLAST != (i == int'(len))) slv = 1'b1;
         MEM_WVALID = 1'b1;
         t = 0;
         while (!MEM_WREADY && t < 50) begin @(negedge CLK); t++; end
         check_val("wready", 64'(MEM_WREADY), 64'd1);
         @(negedge CLK);
         a = beat_addr(addr, len, burst, i);
         if (!in_range(a)) dec = 1'b1;
         else begin
            idx = (a - BASE) >> 3;
            if (ref_mem.exists(idx) || ws[i] == 8'hFF) begin
               cur = ref_mem.exists(idx) ? ref_mem[idx] : 64'd0;
               for (int b = 0; b < 8; b++)
                  if (ws[i][b]) cur[8*b +: 8] = wd[i][8*b +: 8];
               ref_mem[idx] = cur;
            end
         end
      end
      MEM_WVALID = 1'b0;
      MEM_WLAST  = 1'b0;
      exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
      t = 0;
      while (!MEM_BVALID && t < 50) begin @(negedge CLK); t++; end
      for (int h = 0; h <= bhold; h++) begin
         check_val("bvalid", 64'(MEM_BVALID), 64'd1);
         check_val("bresp", 64'(MEM_BRESP), 64'(exp_resp));
         check_val("bid", 64'(MEM_BID), 64'(id));
         if (h < bhold) @(negedge CLK);
      end
      MEM_BREADY = 1'b1;
      @(negedge CLK);
      MEM_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input int hold);
      int t, hs;
      logic [63:0] a, idx;
      logic [1:0] exp_resp;
      bit bad, inr;
      @(negedge CLK);
      MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = len; MEM_ARBURST = burst; MEM_ARVALID = 1'b1;
      t = 0;
      while (!MEM_ARREADY && t < 200) begin @(negedge CLK); t++; end
      check_val("arready", 64'(MEM_ARREADY), 64'd1);
      hs = cyc;
      @(negedge CLK);
      MEM_ARVALID = 1'b0;
      bad = burst_bad(len, burst);
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!MEM_RVALID && t < 50) begin @(negedge CLK); t++; end
         if (i == 0) check_val("r_latency", 64'(cyc - hs), 64'd2);
         a   = beat_addr(addr, len, burst, i);
         inr = in_range(a);
         idx = (a - BASE) >> 3;
         exp_resp = !inr ? 2'b11 : (bad ? 2'b10 : 2'b00);
         for (int h = 0; h <= hold; h++) begin
            check_val("rvalid", 64'(MEM_RVALID), 64'd1);
            check_val("rresp", 64'(MEM_RRESP), 64'(exp_resp));
            check_val("rlast", 64'(MEM_RLAST), 64'(i == int'(len)));
            check_val("rid", 64'(MEM_RID), 64'(id));
            if (!inr) check_val("rdata_oor", MEM_RDATA, 64'd0);
            else if (ref_mem.exists(idx)) check_val("rdata", MEM_RDATA, ref_mem[idx]);
            if (h < hold) @(negedge CLK);
         end
         MEM_RREADY = 1'b1;
         @(negedge CLK);
         MEM_RREADY = 1'b0;
      end
   endtask

   initial begin
      logic [63:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      int          last_at, t;

      repeat (3) @(negedge CLK);
      check_val("rst_awready", 64'(MEM_AWREADY), 64'd0);
      check_val("rst_arready", 64'(MEM_ARREADY), 64'd0);
      check_val("rst_bvalid", 64'(MEM_BVALID), 64'd0);
      check_val("rst_rvalid", 64'(MEM_RVALID), 64'd0);
      check_val("rst_rdata", MEM_RDATA, 64'd0);
      RSTn = 1'b1;
      @(negedge CLK);
      check_val("awready_after_rst", 64'(MEM_AWREADY), 64'd1);
      check_val("arready_after_rst", 64'(MEM_ARREADY), 64'd1);

      // 256-beat fill of words 0..255 and the top 16 words, then full readback
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(BASE, 8'd255, 2'b01, 1'b0, -1, 0);
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(BASE + SPAN - 64'd128, 8'd15, 2'b01, 1'b1, -1, 1);
      do_read(BASE, 8'd255, 2'b01, 1'b0, 0);

      // Directed cases
      for (int i = 0; i < 4; i++) begin wd[i] = 64'h11 * 64'(i + 1); ws[i] = 8'hFF; end
      do_write(BASE, 8'd3, 2'b01, 1'b1, -1, 0);
      do_read(BASE, 8'd3, 2'b01, 1'b1, 0);
      do_read(BASE + 64'h18, 8'd3, 2'b10, 1'b0, 0);
      wd[0] = 64'h1111_1111_2222_2222; ws[0] = 8'hFF;
      do_write(BASE + 64'h28, 8'd0, 2'b01, 1'b0, -1, 0);
      wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; ws[0] = 8'h0F;
      do_write(BASE + 64'h28, 8'd0, 2'b01, 1'b0, -1, 0);
      do_read(BASE + 64'h28, 8'd0, 2'b01, 1'b0, 0);
      check_val("strobe_model", ref_mem[64'd5], 64'h1111_1111_BBBB_BBBB);
      wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
      do_write(64'h7FFF_FFF8, 8'd0, 2'b01, 1'b1, -1, 0);
      do_read(64'h7FFF_FFF8, 8'd0, 2'b01, 1'b1, 0);
      do_read(BASE, 8'd0, 2'b01, 1'b1, 0);
      for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(BASE + 64'h40, 8'd3, 2'b01, 1'b0, 1, 2);
      do_read(BASE, 8'd3, 2'b01, 1'b0, 5);
      do_read(BASE + 64'h40, 8'd3, 2'b11, 1'b1, 0);

      for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      fork
         do_write(BASE + 64'd1600, 8'd7, 2'b01, 1'b1, -1, 0);
         do_read(BASE, 8'd15, 2'b01, 1'b1, 1);
      join
      do_read(BASE + 64'd1600, 8'd7, 2'b01, 1'b0, 0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0:       addr = BASE - 64'd8 * 64'($urandom_range(1, 4));
            1:       addr = BASE + SPAN - 64'd8 * 64'($urandom_range(1, 4));
            default: addr = BASE + 64'd8 * 64'($urandom_range(0, 63));
         endcase
         case ($urandom_range(0, 5))
            0:       len = 8'd0;
            1:       len = 8'd1;
            2:       len = 8'd3;
            3:       len = 8'd7;
            4:       len = 8'd15;
            default: len = 8'($urandom_range(0, 40));
         endcase
         burst = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            last_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            do_write(addr, len, burst, 1'($urandom), last_at, int'($urandom_range(0, 2)));
         end else begin
            do_read(addr, len, burst, 1'($urandom), int'($urandom_range(0, 2)));
         end
      end

      // Reset in the middle of a read burst
      @(negedge CLK);
      MEM_ARID = 1'b1; MEM_ARADDR = BASE; MEM_ARLEN = 8'd7; MEM_ARBURST = 2'b01; MEM_ARVALID = 1'b1;
      t = 0;
      while (!MEM_ARREADY && t < 200) begin @(negedge CLK); t++; end
      @(negedge CLK);
      MEM_ARVALID = 1'b0;
      t = 0;
      while (!MEM_RVALID && t < 50) begin @(negedge CLK); t++; end
      check_val("mid_rvalid", 64'(MEM_RVALID), 64'd1);
      RSTn = 1'b0;
      @(negedge CLK);
      check_val("rst_mid_rvalid", 64'(MEM_RVALID), 64'd0);
      check_val("rst_mid_arready", 64'(MEM_ARREADY), 64'd0);
      check_val("rst_mid_rlast", 64'(MEM_RLAST), 64'd0);
      RSTn = 1'b1;
      @(negedge CLK);
      check_val("rel_arready", 64'(MEM_ARREADY), 64'd1);
      check_val("rel_rvalid", 64'(MEM_RVALID), 64'd0);
      do_read(BASE, 8'd3, 2'b01, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
